prbs_err_stats: RTL and testbench
=================================

# prbs_err_stats

Error-statistics stage sitting directly downstream of the PRBS-31 checker in the Sync/DeSync loopback path. Consumes the checker's per-word error vector and qualifying valid, and tracks checker lock with a hunt/lock state machine. While locked, it accumulates total bits, errored bits and errored words into wide counters, and offers a stable snapshot of them to a reader over a req/ack handshake.

## Interface
- DATA_W, 8, error-vector width (bits per checked word).
- CNT_W, 64, width of total_bits / error_bits / error_words.
- LOCK_WORDS, 64, consecutive error-free words required to declare lock.
- WIN_WORDS, 256, length of the lock-loss observation window, in valid words.
- ERR_WORDS_MAX, 16, errored words within one window that force lock loss.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- err_vec  in  DATA_W  checker error vector; 1 = bit error.
- err_valid  in  1  err_vec qualifier; driven by the DeSync output tvalid.
- clear  in  1  one-cycle pulse; zeroes the statistics counters.
- snap_req  in  1  one-cycle pulse; captures the counters into the snapshot registers.
- snap_ack  in  1  reader has consumed the snapshot.
- snap_valid  out  1  snapshot registers hold valid data.
- snap_total_bits, snap_error_bits, snap_error_words  out  CNT_W  captured counter values.
- locked  out  1  state == LOCKED.
- lock_loss_cnt  out  16  number of LOCKED→HUNT transitions; saturates at 16'hFFFF.

## Operation
- Stage 1: on an edge where err_valid=1, register pop = popcount(err_vec), width clog2(DATA_W+1), together with v1=1. When err_valid=0, v1=0.
- Stage 2 acts on v1 and uses a two-state FSM.
- HUNT:
  - pop==0 increments clean_cnt.
  - pop!=0 sets clean_cnt to 0.
  - When clean_cnt reaches LOCK_WORDS, the FSM goes to LOCKED, clears win_cnt and win_err, and leaves clean_cnt at 0.
  - Words processed in HUNT are never counted, including the word that completes the lock.
- LOCKED:
  - Every v1 word is counted: total_bits += DATA_W, error_bits += pop, error_words += (pop!=0).
  - win_cnt increments per word. win_err increments per errored word.
  - If win_err+(pop!=0) reaches ERR_WORDS_MAX, the FSM goes to HUNT and lock_loss_cnt increments. The triggering word is still counted.
  - Otherwise, when win_cnt reaches WIN_WORDS-1, win_cnt and win_err restart at 0.
- clear:
  - Zeroes total_bits, error_bits and error_words.
  - A clear coincident with a stage-2 word discards that word's contribution.
  - Does not change the FSM, lock_loss_cnt or the snapshot.
- Snapshot:
  - When snap_req=1 and snap_valid=0, the counters' current values (before the same-cycle update) are copied to the snap_* registers, and snap_valid is set on the next edge.
  - snap_req while snap_valid=1 is ignored.
  - snap_ack while snap_valid=1 clears snap_valid.
  - snap_req and snap_ack in the same cycle with snap_valid=1: the ack wins, and the request is ignored.
  - clear and snap_req in the same cycle: the snapshot captures the pre-clear values.

## Timing
- Reset values: all counters, snap_*, snap_valid, locked and lock_loss_cnt are 0. FSM is in HUNT; clean_cnt, win_cnt and win_err are 0. Stage-1 v1 is 0.
- Latency: a word presented at edge N appears in the counters and in locked after edge N+1 (2-register pipeline).
- Throughput: one word per clock, no backpressure. err_valid may toggle arbitrarily.
- rst_n assertion mid-operation clears everything immediately, including an in-flight stage-1 word. Deassertion is synchronised externally.
- Counters wrap modulo 2^CNT_W unless PRBS_STATS_SATURATE_EN is defined.

## Configuration
- PRBS_STATS_SATURATE_EN:
  - Defined: total_bits, error_bits and error_words each saturate at all-ones. Per counter, a saturating add clamps instead of wrapping. A partial add that would overflow clamps to all-ones.
  - Undefined: plain modulo-2^CNT_W adders, with no saturation logic synthesised.
  - lock_loss_cnt saturates in both builds.

## Structure
- Shared package prbs_stats_pkg holds the FSM state enum (HUNT, LOCKED) and the default constants for LOCK_WORDS, WIN_WORDS and ERR_WORDS_MAX.
- One sub-module: prbs_popcount, a parameterised combinational popcount of DATA_W bits, instantiated in stage 1.
- FSM, counters and snapshot logic live in the top.

## Test plan
- Lock acquisition: reset, then 64 clean words → locked=1 two cycles after the 64th word, total_bits=0. Then 100 clean words → total_bits=800, error_bits=0.
- Error counting: locked, inject one word err_vec=8'hA5 → error_bits+=4, error_words+=1, locked stays 1.
- Lock loss:
  - Locked, 16 errored words (8'h01) within 256 → locked=0 and lock_loss_cnt=1; error_words=16.
  - Following words are not counted.
  - 64 further clean words relock the FSM.
- Clear/valid collision: clear pulsed in the cycle a locked word with pop=3 reaches stage 2 → all counters 0 next cycle, locked unchanged.
- Snapshot handshake:
  - snap_req at total_bits=800 → snap_valid=1 with snap_total_bits=800, held stable while traffic continues.
  - A second snap_req is ignored.
  - snap_ack clears snap_valid.
- Saturation: CNT_W=8, locked, 40 words of 8'hFF → error_bits=255 with the macro defined, and error_bits=64 (320 mod 256) without it.

Source files
------------

// File: rtl/prbs_stats_pkg.sv
// Shared types and default thresholds for the PRBS error-statistics stage.
package prbs_stats_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int LOCK_WORDS_DEF    = 64;
    localparam int WIN_WORDS_DEF     = 256;
    localparam int ERR_WORDS_MAX_DEF = 16;

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a DATA_W-bit error vector.
module prbs_popcount #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]           vec_i,
    output logic [$clog2(DATA_W+1)-1:0] pop_o
);
    localparam int POP_W = $clog2(DATA_W + 1);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pop_o = pop_o + POP_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/prbs_err_stats.sv
// Lock tracking, bit/word error statistics and snapshot handshake behind the PRBS-31 checker.
// Define PRBS_STATS_SATURATE_EN to make the statistics counters saturate instead of wrap.
//
// state  | meaning
// HUNT   | waiting for LOCK_WORDS consecutive clean words; nothing is counted
// LOCKED | every word counted; too many errored words in a window drops lock
module prbs_err_stats
    import prbs_stats_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CNT_W         = 64,
    parameter int LOCK_WORDS    = LOCK_WORDS_DEF,
    parameter int WIN_WORDS     = WIN_WORDS_DEF,
    parameter int ERR_WORDS_MAX = ERR_WORDS_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] err_vec,
    input  logic              err_valid,
    input  logic              clear,
    input  logic              snap_req,
    input  logic              snap_ack,
    output logic              snap_valid,
    output logic [CNT_W-1:0]  snap_total_bits,
    output logic [CNT_W-1:0]  snap_error_bits,
    output logic [CNT_W-1:0]  snap_error_words,
    output logic              locked,
    output logic [15:0]       lock_loss_cnt
);
    localparam int POP_W   = $clog2(DATA_W + 1);
    localparam int CLEAN_W = $clog2(LOCK_WORDS + 1);
    localparam int WIN_W   = $clog2(WIN_WORDS);
    localparam int WERR_W  = $clog2(ERR_WORDS_MAX + 1);

    logic [POP_W-1:0]   pop_c, pop_q;
    logic               v1_q;
    state_e             state_q, state_d;
    logic [CLEAN_W-1:0] clean_q, clean_d, clean_inc;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d, werr_inc;
    logic [CNT_W-1:0]   total_q, total_d, ebits_q, ebits_d, ewords_q, ewords_d;
    logic [CNT_W-1:0]   snap_tot_q, snap_tot_d, snap_eb_q, snap_eb_d, snap_ew_q, snap_ew_d;
    logic               snap_valid_q, snap_valid_d;
    logic [15:0]        lock_loss_q, lock_loss_d;
    logic               word_err;

    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
`ifdef PRBS_STATS_SATURATE_EN
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
        return a + b;
`endif
    endfunction

    prbs_popcount #(.DATA_W(DATA_W)) u_popcount (
        .vec_i (err_vec),
        .pop_o (pop_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= err_valid;
            if (err_valid) pop_q <= pop_c;
        end
    end

    always_comb begin
        state_d      = state_q;
        clean_d      = clean_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        total_d      = total_q;
        ebits_d      = ebits_q;
        ewords_d     = ewords_q;
        lock_loss_d  = lock_loss_q;
        snap_tot_d   = snap_tot_q;
        snap_eb_d    = snap_eb_q;
        snap_ew_d    = snap_ew_q;
        snap_valid_d = snap_valid_q;
        word_err     = (pop_q != '0);
        clean_inc    = clean_q + 1'b1;
        werr_inc     = win_err_q + WERR_W'(word_err);

        if (v1_q) begin
            case (state_q)
                HUNT: begin
                    clean_d = word_err ? '0 : clean_inc;
                    if (!word_err && clean_inc == CLEAN_W'(LOCK_WORDS)) begin
                        state_d   = LOCKED;
                        clean_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                LOCKED: begin
                    total_d  = cnt_add(total_q, CNT_W'(DATA_W));
                    ebits_d  = cnt_add(ebits_q, CNT_W'(pop_q));
                    ewords_d = cnt_add(ewords_q, CNT_W'(word_err));
                    if (werr_inc == WERR_W'(ERR_WORDS_MAX)) begin
                        state_d = HUNT;
                        clean_d = '0;
                        if (lock_loss_q != 16'hFFFF) lock_loss_d = lock_loss_q + 16'd1;
                    end else if (win_cnt_q == WIN_W'(WIN_WORDS - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = werr_inc;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clear) begin
            total_d  = '0;
            ebits_d  = '0;
            ewords_d = '0;
        end

        // Capture uses the pre-update (and pre-clear) counter values.
        if (snap_valid_q) begin
            if (snap_ack) snap_valid_d = 1'b0;
        end else if (snap_req) begin
            snap_valid_d = 1'b1;
            snap_tot_d   = total_q;
            snap_eb_d    = ebits_q;
            snap_ew_d    = ewords_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            clean_q      <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            total_q      <= '0;
            ebits_q      <= '0;
            ewords_q     <= '0;
            lock_loss_q  <= '0;
            snap_tot_q   <= '0;
            snap_eb_q    <= '0;
            snap_ew_q    <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clean_q      <= clean_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            total_q      <= total_d;
            ebits_q      <= ebits_d;
            ewords_q     <= ewords_d;
            lock_loss_q  <= lock_loss_d;
            snap_tot_q   <= snap_tot_d;
            snap_eb_q    <= snap_eb_d;
            snap_ew_q    <= snap_ew_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign locked           = (state_q == LOCKED);
    assign lock_loss_cnt    = lock_loss_q;
    assign snap_valid       = snap_valid_q;
    assign snap_total_bits  = snap_tot_q;
    assign snap_error_bits  = snap_eb_q;
    assign snap_error_words = snap_ew_q;

endmodule

// File: tb/tb_prbs_err_stats.sv
// Scoreboard bench: snapshot requests queue expected counters, a monitor checks each new snapshot.
module tb_prbs_err_stats;

    typedef struct {
        logic [63:0] tot;
        logic [63:0] eb;
        logic [63:0] ew;
        logic        lk;
        logic [15:0] ll;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  ev1, ev2;
    logic        val1, val2, clr1, clr2, req1, req2, ack1, ack2;
    logic        sv1, sv2, lk1, lk2;
    logic [63:0] st1, sb1, sw1;
    logic [7:0]  st2, sb2, sw2;
    logic [15:0] ll1, ll2;

    prbs_err_stats #(.DATA_W(8), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .err_vec(ev1), .err_valid(val1), .clear(clr1),
        .snap_req(req1), .snap_ack(ack1), .snap_valid(sv1),
        .snap_total_bits(st1), .snap_error_bits(sb1), .snap_error_words(sw1),
        .locked(lk1), .lock_loss_cnt(ll1)
    );

    prbs_err_stats #(.DATA_W(8), .CNT_W(8), .ERR_WORDS_MAX(64)) dut_sat (
        .clk(clk), .rst_n(rst_n), .err_vec(ev2), .err_valid(val2), .clear(clr2),
        .snap_req(req2), .snap_ack(ack2), .snap_valid(sv2),
        .snap_total_bits(st2), .snap_error_bits(sb2), .snap_error_words(sw2),
        .locked(lk2), .lock_loss_cnt(ll2)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m_e;
    logic prev1 = 1'b0, prev2 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (sv1 && !prev1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL snap1_unexpected: got snapshot, expected none");
            end else begin
                m_e = q1.pop_front();
                chk("snap1_total_bits", st1, m_e.tot);
                chk("snap1_error_bits", sb1, m_e.eb);
                chk("snap1_error_words", sw1, m_e.ew);
                chk("snap1_locked", 64'(lk1), 64'(m_e.lk));
                chk("snap1_lock_loss", 64'(ll1), 64'(m_e.ll));
            end
        end
        if (sv2 && !prev2) begin
            if (q2.size() == 0) begin
                n_chk++;
                $display("FAIL snap2_unexpected: got snapshot, expected none");
            end else begin
                m_e = q2.pop_front();
                chk("snap2_total_bits", 64'(st2), m_e.tot);
                chk("snap2_error_bits", 64'(sb2), m_e.eb);
                chk("snap2_error_words", 64'(sw2), m_e.ew);
                chk("snap2_locked", 64'(lk2), 64'(m_e.lk));
            end
        end
        prev1 = sv1;
        prev2 = sv2;
    end

    // Words are driven on negedges; returns once the last word has reached the counters.
    task automatic send(input int which, input logic [7:0] v, input int n);
        repeat (n) begin
            @(negedge clk);
            if (which == 1) begin ev1 = v; val1 = 1'b1; end
            else begin ev2 = v; val2 = 1'b1; end
        end
        @(negedge clk);
        val1 = 1'b0;
        val2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic snap(input int which, input logic with_clear, input logic [63:0] tot,
                        input logic [63:0] eb, input logic [63:0] ew, input logic lk,
                        input logic [15:0] ll);
        exp_t e;
        e.tot = tot; e.eb = eb; e.ew = ew; e.lk = lk; e.ll = ll;
        @(negedge clk);
        if (which == 1) begin req1 = 1'b1; clr1 = with_clear; q1.push_back(e); end
        else begin req2 = 1'b1; q2.push_back(e); end
        @(negedge clk);
        req1 = 1'b0; req2 = 1'b0; clr1 = 1'b0;
        for (int i = 0; i < 8 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) begin
            n_chk++;
            $display("FAIL snap_timeout: got no snapshot, expected one on dut %0d", which);
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic ack(input int which);
        @(negedge clk);
        if (which == 1) ack1 = 1'b1; else ack2 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0; ack2 = 1'b0;
        chk("snap_valid_after_ack", 64'(which == 1 ? sv1 : sv2), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ev1 = '0; ev2 = '0; val1 = 0; val2 = 0; clr1 = 0; clr2 = 0;
        req1 = 0; req2 = 0; ack1 = 0; ack2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_locked", 64'(lk1), 64'(0));
        chk("reset_snap_valid", 64'(sv1), 64'(0));
        chk("reset_lock_loss", 64'(ll1), 64'(0));
        chk("reset_snap_total", st1, 64'(0));
        rst_n = 1'b1;

        // Lock acquisition: locked rises two edges after the 64th clean word.
        repeat (64) begin
            @(negedge clk);
            ev1 = 8'h00; val1 = 1'b1;
        end
        @(negedge clk);
        val1 = 1'b0;
        chk("locked_one_edge_after_64th", 64'(lk1), 64'(0));
        @(negedge clk);
        chk("locked_two_edges_after_64th", 64'(lk1), 64'(1));
        snap(1, 0, 0, 0, 0, 1, 0);
        ack(1);

        send(1, 8'h00, 100);
        snap(1, 0, 800, 0, 0, 1, 0);
        send(1, 8'h00, 10);
        chk("snap_hold_total", st1, 64'd800);
        @(negedge clk); req1 = 1'b1;
        @(negedge clk); req1 = 1'b0;
        chk("second_req_valid", 64'(sv1), 64'(1));
        chk("second_req_ignored", st1, 64'd800);
        ack(1);

        send(1, 8'hA5, 1);
        snap(1, 0, 888, 4, 1, 1, 0);
        ack(1);

        // 145 clean words close the 256-word window so the A5 error is forgotten.
        send(1, 8'h00, 145);
        send(1, 8'h01, 16);
        chk("lock_lost", 64'(lk1), 64'(0));
        chk("lock_loss_cnt", 64'(ll1), 64'(1));
        send(1, 8'h01, 3);
        send(1, 8'h00, 64);
        chk("relocked", 64'(lk1), 64'(1));
        snap(1, 0, 2176, 20, 17, 1, 1);
        ack(1);

        // Clear coincident with a pop=3 word reaching stage 2.
        @(negedge clk); ev1 = 8'h07; val1 = 1'b1;
        @(negedge clk); val1 = 1'b0; clr1 = 1'b1;
        @(negedge clk); clr1 = 1'b0;
        chk("clear_keeps_lock", 64'(lk1), 64'(1));
        snap(1, 0, 0, 0, 0, 1, 1);
        ack(1);

        send(1, 8'h00, 2);
        snap(1, 1, 16, 0, 0, 1, 1);
        ack(1);
        snap(1, 0, 0, 0, 0, 1, 1);
        ack(1);

        send(2, 8'h00, 64);
        send(2, 8'hFF, 40);
`ifdef PRBS_STATS_SATURATE_EN
        snap(2, 0, 255, 255, 40, 1, 0);
`else
        snap(2, 0, 64, 64, 40, 1, 0);
`endif
        ack(2);

        // Asynchronous reset mid-traffic.
        @(negedge clk); ev1 = 8'h00; val1 = 1'b1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 64'(lk1), 64'(0));
        chk("async_rst_lock_loss", 64'(ll1), 64'(0));
        chk("async_rst_sat_locked", 64'(lk2), 64'(0));
        val1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
